// File: rtl/card_renderer_pkg.sv
// Shared opcodes, FSM states, glyph placement and fixed ink colours for the card renderer.
// No logic here; imported by the renderer top and its glyph ROM.
package card_renderer_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_FACE  = 2'd1,
        CMD_BACK  = 2'd2,
        CMD_ERASE = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RECT = 2'd2
    } state_e;

    localparam int GLYPH_W  = 3;
    localparam int GLYPH_H  = 5;
    localparam int GLYPH_OX = 2;
    localparam int GLYPH_OY = 2;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/card_glyph_rom.sv
// Combinational 3x5 rank glyph lookup; zero latency, no flow control.
// Invalid ranks and out-of-range row/col read as background (0).
module card_glyph_rom
    import card_renderer_pkg::*;
(
    input  logic [3:0] rank_i,
    input  logic [2:0] row_i,
    input  logic [1:0] col_i,
    output logic       pix_o
);

    logic [14:0] bits;
    logic [3:0]  idx;

    // Five rows of three bits, top row first, leftmost column in the MSB of each row.
    always_comb begin
        case (rank_i)
            4'd1:    bits = 15'b010_101_111_101_101;
            4'd2:    bits = 15'b111_001_111_100_111;
            4'd3:    bits = 15'b111_001_111_001_111;
            4'd4:    bits = 15'b101_101_111_001_001;
            4'd5:    bits = 15'b111_100_111_001_111;
            4'd6:    bits = 15'b111_100_111_101_111;
            4'd7:    bits = 15'b111_001_001_001_001;
            4'd8:    bits = 15'b111_101_111_101_111;
            4'd9:    bits = 15'b111_101_111_001_111;
            4'd10:   bits = 15'b111_010_010_010_010;
            4'd11:   bits = 15'b001_001_001_101_111;
            4'd12:   bits = 15'b111_101_101_111_001;
            4'd13:   bits = 15'b101_110_100_110_101;
            default: bits = '0;
        endcase
        idx   = {1'b0, row_i} * 4'd3 + {2'b00, col_i};
        pix_o = 1'b0;
        if (row_i < 3'(GLYPH_H) && col_i < 2'(GLYPH_W))
            pix_o = bits[4'd14 - idx];
    end

endmodule

// File: rtl/card_renderer.sv
// One drawing command per write, one registered pixel per cycle; waitrequest holds off new writes.
// CARD_BORDER_EN adds a black 1-pixel outline to FACE/BACK without changing cycle counts.
module card_renderer
    import card_renderer_pkg::*;
#(
    parameter int            SCR_W       = 160,
    parameter int            SCR_H       = 120,
    parameter int            XW          = 8,
    parameter int            YW          = 7,
    parameter int            CW          = 3,
    parameter int            CARD_W      = 12,
    parameter int            CARD_H      = 16,
    parameter logic [CW-1:0] BG_COLOUR   = 3'b010,
    parameter logic [CW-1:0] FACE_COLOUR = 3'b111,
    parameter logic [CW-1:0] BACK_COLOUR = 3'b001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [1:0]       cmd,
    input  logic [5:0]       card,
    input  logic [XW+YW-1:0] orig,
    output logic             waitrequest,
    output logic [XW-1:0]    vga_x,
    output logic [YW-1:0]    vga_y,
    output logic [CW-1:0]    vga_colour,
    output logic             vga_plot
);

    state_e        state_q;
    cmd_e          cmd_q;
    logic [5:0]    card_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic [XW:0]   cx_q;
    logic [YW:0]   cy_q;

    logic [XW:0]   px_d, x_last;
    logic [YW:0]   py_d, y_last;
    logic          in_glyph, is_pip, rank_ok, glyph_bit;
    logic [CW-1:0] ink, rect_colour;
    logic [2:0]    g_row;
    logic [1:0]    g_col;

    // Counters are relative to the card origin in RECT, absolute in CLR; one extra bit avoids wrap.
    assign px_d   = (state_q == CLR) ? cx_q : ({1'b0, ox_q} + cx_q);
    assign py_d   = (state_q == CLR) ? cy_q : ({1'b0, oy_q} + cy_q);
    assign x_last = (state_q == CLR) ? (XW+1)'(SCR_W - 1) : (XW+1)'(CARD_W - 1);
    assign y_last = (state_q == CLR) ? (YW+1)'(SCR_H - 1) : (YW+1)'(CARD_H - 1);

    assign in_glyph = (cx_q >= (XW+1)'(GLYPH_OX)) && (cx_q < (XW+1)'(GLYPH_OX + GLYPH_W)) &&
                      (cy_q >= (YW+1)'(GLYPH_OY)) && (cy_q < (YW+1)'(GLYPH_OY + GLYPH_H));
    assign is_pip   = (cx_q == (XW+1)'(CARD_W - 3)) && (cy_q == (YW+1)'(CARD_H - 3));
    assign rank_ok  = (card_q[3:0] >= 4'd1) && (card_q[3:0] <= 4'd13);
    assign ink      = (card_q[5:4] < 2'd2) ? CW'(RED) : CW'(BLACK);
    assign g_col    = 2'(cx_q - (XW+1)'(GLYPH_OX));
    assign g_row    = 3'(cy_q - (YW+1)'(GLYPH_OY));

    card_glyph_rom u_glyph (
        .rank_i (card_q[3:0]),
        .row_i  (g_row),
        .col_i  (g_col),
        .pix_o  (glyph_bit)
    );

`ifdef CARD_BORDER_EN
    logic on_edge;
    assign on_edge = (cx_q == '0) || (cx_q == (XW+1)'(CARD_W - 1)) ||
                     (cy_q == '0) || (cy_q == (YW+1)'(CARD_H - 1));
`endif

    always_comb begin
        rect_colour = BG_COLOUR;
        case (cmd_q)
            CMD_FACE: rect_colour = ((in_glyph && glyph_bit) || (is_pip && rank_ok)) ? ink : FACE_COLOUR;
            CMD_BACK: rect_colour = (cx_q[1] ^ cy_q[1]) ? FACE_COLOUR : BACK_COLOUR;
            default:  rect_colour = BG_COLOUR;
        endcase
`ifdef CARD_BORDER_EN
        if ((cmd_q == CMD_FACE || cmd_q == CMD_BACK) && on_edge)
            rect_colour = CW'(BLACK);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_CLEAR;
            card_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            waitrequest <= 1'b0;
            vga_plot    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
        end else begin
            vga_plot <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write) begin
                        cmd_q       <= cmd_e'(cmd);
                        card_q      <= card;
                        ox_q        <= orig[XW+YW-1:YW];
                        oy_q        <= orig[YW-1:0];
                        cx_q        <= '0;
                        cy_q        <= '0;
                        waitrequest <= 1'b1;
                        state_q     <= (cmd_e'(cmd) == CMD_CLEAR) ? CLR : RECT;
                    end
                end
                CLR, RECT: begin
                    vga_x      <= px_d[XW-1:0];
                    vga_y      <= py_d[YW-1:0];
                    vga_colour <= (state_q == CLR) ? BG_COLOUR : rect_colour;
                    // Off-screen pixels still take their cycle, they just are not plotted.
                    vga_plot   <= (px_d < (XW+1)'(SCR_W)) && (py_d < (YW+1)'(SCR_H));
                    if (cx_q == x_last) begin
                        cx_q <= '0;
                        if (cy_q == y_last) begin
                            cy_q        <= '0;
                            state_q     <= IDLE;
                            waitrequest <= 1'b0;
                        end else begin
                            cy_q <= cy_q + (YW+1)'(1);
                        end
                    end else begin
                        cx_q <= cx_q + (XW+1)'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_renderer.sv
// Drives directed and random drawing commands and compares every plotted pixel and busy length
// against a pixel-list reference built from the card drawing rules.
module tb_card_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [5:0]  card = 6'd0;
    logic [14:0] orig = 15'd0;
    logic        waitrequest;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          exp_busy;

    card_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .cmd         (cmd),
        .card        (card),
        .orig        (orig),
        .waitrequest (waitrequest),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Glyph art as 15-character strings, rows top to bottom, '#' = ink.
    function automatic bit glyph_on(int rank, int r, int c);
        string s;
        case (rank)
            1:       s = ".#.#.#####.##.#";
            2:       s = "###..#####..###";
            3:       s = "###..####..####";
            4:       s = "#.##.####..#..#";
            5:       s = "####..###..####";
            6:       s = "####..####.####";
            7:       s = "###..#..#..#..#";
            8:       s = "####.#####.####";
            9:       s = "####.####..####";
            10:      s = "###.#..#..#..#.";
            11:      s = "..#..#..##.####";
            12:      s = "####.##.####..#";
            13:      s = "#.###.#..##.#.#";
            default: s = "";
        endcase
        if (rank < 1 || rank > 13 || r < 0 || r > 4 || c < 0 || c > 2)
            return 1'b0;
        return s[r*3 + c] == "#";
    endfunction

    function automatic logic [2:0] model_colour(int op, logic [5:0] cd, int rx, int ry);
        int         rank;
        logic [2:0] ink;
        rank = int'(cd[3:0]);
        ink  = (cd[5:4] <= 2'd1) ? 3'b100 : 3'b000;
`ifdef CARD_BORDER_EN
        if ((op == 1 || op == 2) && (rx == 0 || rx == 11 || ry == 0 || ry == 15))
            return 3'b000;
`endif
        if (op == 3)
            return 3'b010;
        if (op == 2)
            return (((rx / 2) + (ry / 2)) % 2 == 0) ? 3'b001 : 3'b111;
        if (rank >= 1 && rank <= 13 && (glyph_on(rank, ry - 2, rx - 2) || (rx == 9 && ry == 13)))
            return ink;
        return 3'b111;
    endfunction

    task automatic build_expected(input int op, input logic [5:0] cd, input int ox, input int oy);
        exp_q.delete();
        if (op == 0) begin
            for (int y = 0; y < 120; y++)
                for (int x = 0; x < 160; x++)
                    exp_q.push_back({8'(x), 7'(y), 3'b010});
            exp_busy = 160 * 120;
        end else begin
            for (int ry = 0; ry < 16; ry++)
                for (int rx = 0; rx < 12; rx++)
                    if (ox + rx < 160 && oy + ry < 120)
                        exp_q.push_back({8'(ox + rx), 7'(oy + ry), model_colour(op, cd, rx, ry)});
            exp_busy = 12 * 16;
        end
    endtask

    function automatic logic [7:0] colour_at(int x, int y);
        foreach (got_q[i])
            if (got_q[i][17:10] == 8'(x) && got_q[i][9:3] == 7'(y))
                return {5'd0, got_q[i][2:0]};
        return 8'hff;
    endfunction

    task automatic run_cmd(input int op, input logic [5:0] cd, input int ox, input int oy,
                           input bit poke, input string tag);
        int busy;
        build_expected(op, cd, ox, oy);
        got_q.delete();
        @(negedge clk);
        write = 1'b1; cmd = 2'(op); card = cd; orig = {8'(ox), 7'(oy)};
        @(negedge clk);
        write = 1'b0;
        busy = 0;
        while (waitrequest && busy < exp_busy + 20) begin
            if (vga_plot)
                got_q.push_back({vga_x, vga_y, vga_colour});
            if (poke && busy == 40) begin
                write = 1'b1; cmd = 2'd3;
            end else begin
                write = 1'b0;
            end
            busy++;
            @(negedge clk);
        end
        write = 1'b0;
        if (vga_plot)
            got_q.push_back({vga_x, vga_y, vga_colour});
        chk({tag, " busy"}, busy, exp_busy);
        chk({tag, " plots"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s px%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        int guard;

        repeat (3) @(negedge clk);
        chk("reset wait", waitrequest, 0);
        chk("reset plot", vga_plot, 0);
        chk("reset x", vga_x, 0);
        chk("reset y", vga_y, 0);
        chk("reset colour", vga_colour, 0);
        rst_n = 1'b1;

        run_cmd(0, 6'd0, 0, 0, 1'b0, "clear");
        run_cmd(1, 6'b00_0001, 10, 20, 1'b0, "face ace");
        chk("face pip", colour_at(19, 33), 8'h04);
        run_cmd(2, 6'd0, 154, 110, 1'b0, "back clipped");
        run_cmd(1, 6'b11_1100, 40, 50, 1'b1, "face poked");
        run_cmd(3, 6'd0, 40, 50, 1'b0, "erase");

        // Abort a clear partway through with reset.
        @(negedge clk);
        write = 1'b1; cmd = 2'd0;
        @(negedge clk);
        write = 1'b0;
        n = 0;
        guard = 0;
        while (n < 500 && guard < 2000) begin
            if (vga_plot)
                n++;
            guard++;
            @(negedge clk);
        end
        chk("pre-reset plots", n, 500);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort plot", vga_plot, 0);
        chk("abort wait", waitrequest, 0);
        rst_n = 1'b1;
        run_cmd(1, 6'b10_0101, 30, 40, 1'b0, "post-reset face");

        run_cmd(1, 6'b00_0000, 10, 20, 1'b0, "face blank");

        for (int k = 0; k < 40; k++)
            run_cmd(int'($urandom_range(1, 3)), 6'($urandom), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
